axi_master_bridge: RTL and testbench

- Single-outstanding AXI4 master that converts one CPU-side memory request (instruction fetch or data load/store) into a single-beat AXI read or write transaction.
- Sits between a core memory port and a master port of the AXI interconnect; it is the initiator side of the slave protocol used by the system's SRAM wrappers.
- The core holds its request while `core_stall` is high and sees the result in a one-cycle completion slot.

---
 rtl/axi_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_axi_master_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: one core request -> one single-beat AXI read or write.
// Latency: zero-wait read IDLE,AR,R,DONE; write IDLE,AW,W,B,DONE; result in a one-cycle DONE slot.
// Backpressure: core_stall holds the core while any AXI channel waits; VALIDs hold until READY.
module axi_master_bridge #(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_web,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic        AWVALID,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_web;
    logic [31:0] r_rdata;
    logic        r_err;

    // Response ID and RLAST are not checked: only one beat is ever outstanding.
    logic w_unused;
    assign w_unused = ^{RID, RLAST, BID};

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Request latch, read data capture and response error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_web   <= 4'hF;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && core_req) begin
                r_addr  <= core_addr;
                r_wdata <= core_wdata;
                r_web   <= core_web;
                r_err   <= 1'b0;
            end
            if (r_state == S_R && RVALID) begin
                r_rdata <= RDATA;
                r_err   <= (RRESP != 2'b00);
            end
            if (r_state == S_B && BVALID) begin
                r_err <= (BRESP != 2'b00);
            end
        end
    end

    // Next-state logic and per-state channel handshake outputs.
    always_comb begin
        w_next     = r_state;
        core_stall = 1'b0;
        core_err   = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        WLAST      = 1'b0;
        WSTRB      = 4'hF;
        BREADY     = 1'b0;
        case (r_state)
            S_IDLE: begin
                core_stall = core_req;
                if (core_req) w_next = core_we ? S_AW : S_AR;
            end
            S_AR: begin
                core_stall = 1'b1;
                ARVALID    = 1'b1;
                if (ARREADY) w_next = S_R;
            end
            S_R: begin
                core_stall = 1'b1;
                RREADY     = 1'b1;
                if (RVALID) w_next = S_DONE;
            end
            S_AW: begin
                core_stall = 1'b1;
                AWVALID    = 1'b1;
                if (AWREADY) w_next = S_W;
            end
            S_W: begin
                core_stall = 1'b1;
                WVALID     = 1'b1;
                WLAST      = 1'b1;
                WSTRB      = r_web;
                if (WREADY) w_next = S_B;
            end
            S_B: begin
                core_stall = 1'b1;
                BREADY     = 1'b1;
                if (BVALID) w_next = S_DONE;
            end
            S_DONE: begin
                core_err = r_err;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign core_rdata = r_rdata;
    assign ARID       = MASTER_ID;
    assign ARADDR     = r_addr;
    assign ARLEN      = 4'd0;
    assign ARSIZE     = 3'b010;
    assign ARBURST    = 2'b01;
    assign AWID       = MASTER_ID;
    assign AWADDR     = r_addr;
    assign AWLEN      = 4'd0;
    assign AWSIZE     = 3'b010;
    assign AWBURST    = 2'b01;
    assign WDATA      = r_wdata;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge acting as the AXI slave and the core.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Expected DONE results are queued at request time and popped in the DONE cycle.
module tb_axi_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_web;
    logic [31:0] core_rdata;
    logic        core_stall, core_err;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [3:0]  RID, BID, WSTRB;
    logic [31:0] RDATA;
    logic [1:0]  RRESP, BRESP;
    logic        RLAST, RVALID, RREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rdata;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    axi_master_bridge #(.MASTER_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_web(core_web), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_err(core_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DONE cycle: compare against the oldest queued expectation.
    task automatic check_done();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("done_stall", core_stall, 0);
            chk("done_rdata", core_rdata, e.rdata);
            chk("done_err",   core_err,   e.err);
            chk("done_noarv", ARVALID, 0);
            chk("done_noawv", AWVALID, 0);
        end
    endtask

    // Back in IDLE after DONE; with hold the core request is still asserted.
    task automatic check_idle(input bit hold);
        @(negedge clk);
        #1;
        chk("idle_err",   core_err, 0);
        chk("idle_stall", core_stall, hold);
        chk("idle_arv",   ARVALID, 0);
        chk("idle_awv",   AWVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_wait, input int r_wait,
                           input bit hold);
        logic [31:0] old;
        core_req = 1'b1; core_we = 1'b0; core_addr = addr;
        m_rdata = data;
        sb.push_back('{rdata: data, err: (resp != 2'b00)});
        #1;
        chk("rd_idle_stall", core_stall, 1);
        @(negedge clk);                       // AR
        if (!hold) core_req = 1'b0;
        core_addr = ~addr;
        for (int i = 0; i < ar_wait; i++) begin
            #1;
            chk("rd_arv_hold",  ARVALID, 1);
            chk("rd_araddr_st", ARADDR, addr);
            @(negedge clk);
        end
        ARREADY = 1'b1;
        #1;
        chk("rd_arvalid", ARVALID, 1);
        chk("rd_araddr",  ARADDR, addr);
        chk("rd_arlen",   ARLEN, 0);
        chk("rd_arsize",  ARSIZE, 3'b010);
        chk("rd_arburst", ARBURST, 2'b01);
        chk("rd_arid",    ARID, 0);
        chk("rd_ar_stall", core_stall, 1);
        chk("rd_ar_awv",  AWVALID, 0);
        @(negedge clk);                       // R
        ARREADY = 1'b0;
        old = core_rdata;
        for (int i = 0; i < r_wait; i++) begin
            #1;
            chk("rd_rready_hold", RREADY, 1);
            chk("rd_no_2nd_ar",   ARVALID, 0);
            chk("rd_rdata_held",  core_rdata, old);
            chk("rd_r_stall",     core_stall, 1);
            @(negedge clk);
        end
        RVALID = 1'b1; RDATA = data; RRESP = resp; RLAST = 1'b1;
        #1;
        chk("rd_rready", RREADY, 1);
        chk("rd_r_stall2", core_stall, 1);
        @(negedge clk);                       // DONE
        RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0;
        check_done();
        check_idle(hold);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] web, input logic [1:0] resp,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input bit hold);
        core_req = 1'b1; core_we = 1'b1; core_addr = addr;
        core_wdata = data; core_web = web;
        sb.push_back('{rdata: m_rdata, err: (resp != 2'b00)});
        #1;
        chk("wr_idle_stall", core_stall, 1);
        @(negedge clk);                       // AW
        if (!hold) core_req = 1'b0;
        core_wdata = ~data; core_web = ~web; core_addr = ~addr;
        for (int i = 0; i < aw_wait; i++) begin
            #1;
            chk("wr_awv_hold",  AWVALID, 1);
            chk("wr_awaddr_st", AWADDR, addr);
            chk("wr_no_early_w", WVALID, 0);
            chk("wr_wstrb_idle", WSTRB, 4'hF);
            @(negedge clk);
        end
        AWREADY = 1'b1;
        #1;
        chk("wr_awvalid", AWVALID, 1);
        chk("wr_awaddr",  AWADDR, addr);
        chk("wr_awlen",   AWLEN, 0);
        chk("wr_awsize",  AWSIZE, 3'b010);
        chk("wr_awburst", AWBURST, 2'b01);
        chk("wr_aw_wv",   WVALID, 0);
        chk("wr_aw_arv",  ARVALID, 0);
        @(negedge clk);                       // W
        AWREADY = 1'b0;
        for (int i = 0; i <= w_wait; i++) begin
            if (i == w_wait) WREADY = 1'b1;
            #1;
            chk("wr_wvalid", WVALID, 1);
            chk("wr_wlast",  WLAST, 1);
            chk("wr_wdata",  WDATA, data);
            chk("wr_wstrb",  WSTRB, web);
            chk("wr_w_awv",  AWVALID, 0);
            @(negedge clk);
        end
        WREADY = 1'b0;                        // B
        for (int i = 0; i <= b_wait; i++) begin
            if (i == b_wait) begin BVALID = 1'b1; BRESP = resp; end
            #1;
            chk("wr_bready",  BREADY, 1);
            chk("wr_b_wv",    WVALID, 0);
            chk("wr_b_wstrb", WSTRB, 4'hF);
            chk("wr_b_stall", core_stall, 1);
            @(negedge clk);
        end
        BVALID = 1'b0; BRESP = 2'b00;         // DONE
        check_done();
        check_idle(hold);
    endtask

    initial begin
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_web = 4'hF; core_wdata = 32'h0;
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RID = 4'h0; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
        BID = 4'h0; BRESP = 2'b00; BVALID = 1'b0;
        m_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid",  WVALID, 0);
        chk("rst_rready",  RREADY, 0);
        chk("rst_bready",  BREADY, 0);
        chk("rst_wlast",   WLAST, 0);
        chk("rst_araddr",  ARADDR, 0);
        chk("rst_awaddr",  AWADDR, 0);
        chk("rst_wdata",   WDATA, 0);
        chk("rst_rdata",   core_rdata, 0);
        chk("rst_wstrb",   WSTRB, 4'hF);
        chk("rst_err",     core_err, 0);
        chk("rst_stall",   core_stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: zero-wait read
        do_read(32'h0000_0104, 32'hDEADBEEF, 2'b00, 0, 0, 1'b0);
        // 2: write with AWREADY delayed 3 cycles
        do_write(32'h0000_0200, 32'h12345678, 4'b1100, 2'b00, 3, 0, 0, 1'b0);
        // 3: read with RVALID delayed 5 cycles
        do_read(32'h0000_0308, 32'hCAFEF00D, 2'b00, 1, 5, 1'b0);
        // 4: back-to-back read then write with core_req held high
        do_read(32'h0000_0400, 32'h0BADC0DE, 2'b00, 0, 0, 1'b1);
        do_write(32'h0000_0404, 32'hA5A5A5A5, 4'b0000, 2'b00, 0, 1, 2, 1'b0);
        // 5: SLVERR on write, then OKAY read clears the error
        do_write(32'h0000_0500, 32'h55AA55AA, 4'b1010, 2'b10, 0, 0, 1, 1'b0);
        do_read(32'h0000_0504, 32'h11223344, 2'b00, 0, 0, 1'b0);
        do_read(32'h0000_0508, 32'h99887766, 2'b11, 0, 1, 1'b0);

        // 6: reset while in W with WVALID high
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h600;
        core_wdata = 32'hFEEDFACE; core_web = 4'b0011;
        @(negedge clk);                       // AW
        core_req = 1'b0;
        AWREADY = 1'b1;
        @(negedge clk);                       // W
        AWREADY = 1'b0;
        #1;
        chk("rstw_wvalid_pre", WVALID, 1);
        chk("rstw_wstrb_pre",  WSTRB, 4'b0011);
        rst = 1'b1;
        #1;
        chk("rstw_wvalid", WVALID, 0);
        chk("rstw_bready", BREADY, 0);
        chk("rstw_wlast",  WLAST, 0);
        chk("rstw_wstrb",  WSTRB, 4'hF);
        chk("rstw_wdata",  WDATA, 0);
        chk("rstw_rdata",  core_rdata, 0);
        chk("rstw_stall",  core_stall, 0);
        @(negedge clk);
        WREADY = 1'b1;                        // late WREADY must not restart anything
        #1;
        chk("rstw_hold_wv", WVALID, 0);
        chk("rstw_hold_bready", BREADY, 0);
        @(negedge clk);
        WREADY = 1'b0;
        rst = 1'b0;
        m_rdata = 32'h0;
        #1;
        chk("rstw_idle_awv", AWVALID, 0);
        chk("rstw_idle_bready", BREADY, 0);
        do_read(32'h0000_0700, 32'h76543210, 2'b00, 0, 0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
